arb_client_agent: RTL and testbench

ARB_CLIENT_AGENT -- requirements
Module: arb_client_agent

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_client_fifo.sv | 55 +++++
 rtl/arb_client_agent.sv | 117 +++++++++++
 tb/tb_arb_client_agent.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for arbiter clients: the client FSM state encoding and
// the default grant-hold length the arbiter and its clients agree on.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    YIELD = 2'd3
  } client_state_e;

  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/arb_client_fifo.sv
// Synchronous FIFO buffering producer words ahead of the arbitrated bus.
// Head word is presented combinationally on rd_data; count spans 0..DEPTH.
module arb_client_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Guard locally as well so the buffer can never overrun or underrun.
  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/arb_client_agent.sv
// Arbiter client: buffers producer words, requests one arbiter port, and
// drains in bursts of at most MAX_BURST before yielding for one cycle.
module arb_client_agent
  import arb_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int MAX_BURST    = ARB_MAX_BURST,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     req,
  input  logic                     grant,
  output logic                     bus_valid,
  output logic [DATA_W-1:0]        bus_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     starved,
  output logic                     spurious_grant
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);

  client_state_e      state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d, burst_inc;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_next;
  logic               push, pop;

  arb_client_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (bus_data),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state decisions look at the post-edge occupancy so the FSM never
  // requests with an empty buffer nor idles with data pending.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    push       = in_valid && in_ready;
    count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    burst_inc  = (state_q == XFER) ? burst_q + BURST_W'(1) : BURST_W'(1);

    unique case (state_q)
      IDLE: begin
        if (count_next != '0) state_d = REQ;
      end
      REQ, XFER: begin
        if (count_next == '0) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (grant) begin
          if (burst_inc == BURST_W'(MAX_BURST)) begin
            state_d = YIELD;
            burst_d = '0;
          end else begin
            state_d = XFER;
            burst_d = burst_inc;
          end
        end else begin
          state_d = REQ;
          burst_d = '0;
        end
      end
      YIELD: begin
        state_d = (count_next != '0) ? REQ : IDLE;
        burst_d = '0;
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase

    if (req && !grant && (state_d == REQ || state_d == XFER)) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
  end

  // Reset gating keeps in_ready and spurious_grant low while reset is held.
  always_comb begin
    req            = (state_q == REQ) || (state_q == XFER);
    pop            = req && grant;
    bus_valid      = pop;
    in_ready       = !reset && (fifo_count < CNT_W'(DEPTH));
    spurious_grant = !reset && grant && !req;
    starved        = (wait_q >= WAIT_W'(STARVE_LIMIT));
  end

endmodule

// File: tb/tb_arb_client_agent.sv
// Self-checking bench for arb_client_agent: directed scenarios then random
// traffic, every cycle compared against a queue-based behavioural model.
module tb_arb_client_agent;

  localparam int DATA_W       = 8;
  localparam int DEPTH        = 8;
  localparam int MAX_BURST    = 4;
  localparam int STARVE_LIMIT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req;
  logic              grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [3:0]        fifo_count;
  logic              starved;
  logic              spurious_grant;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a word queue, whether a request is outstanding,
  // transfers in the current tenure, and consecutive ungranted cycles.
  logic [DATA_W-1:0] m_q[$];
  bit                m_req;
  int                m_burst;
  int                m_wait;

  arb_client_agent #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .req            (req),
    .grant          (grant),
    .bus_valid      (bus_valid),
    .bus_data       (bus_data),
    .fifo_count     (fifo_count),
    .starved        (starved),
    .spurious_grant (spurious_grant)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_req   = 1'b0;
    m_burst = 0;
    m_wait  = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare mid-low-phase,
  // then advance the model across the rising edge.
  task automatic apply_stimulus(input bit v, input logic [DATA_W-1:0] d, input bit g, input bit tie);
    bit push, pop, hit, nreq;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    #1;
    grant = tie ? req : g;
    #1;
    push = v && (m_q.size() < DEPTH);
    pop  = m_req && grant;
    check_output("req", req, m_req);
    check_output("bus_valid", bus_valid, pop);
    check_output("fifo_count", fifo_count, m_q.size());
    check_output("in_ready", in_ready, m_q.size() < DEPTH);
    check_output("starved", starved, m_wait >= STARVE_LIMIT);
    check_output("spurious_grant", spurious_grant, grant && !m_req);
    if (pop) check_output("bus_data", bus_data, m_q[0]);
    @(posedge clk);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    hit = 1'b0;
    if (m_req) begin
      m_burst = pop ? m_burst + 1 : 0;
      if (pop && m_burst == MAX_BURST) begin
        hit     = 1'b1;
        m_burst = 0;
      end
      nreq = (m_q.size() > 0) && !hit;
      if (m_q.size() == 0) m_burst = 0;
    end else begin
      nreq = (m_q.size() > 0);
    end
    m_wait = (m_req && nreq && !grant) ? m_wait + 1 : 0;
    m_req  = nreq;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    grant    = 1'b1;
    #1;
    model_clear();
    check_output("rst_req", req, 1'b0);
    check_output("rst_bus_valid", bus_valid, 1'b0);
    check_output("rst_fifo_count", fifo_count, 0);
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_starved", starved, 1'b0);
    check_output("rst_spurious", spurious_grant, 1'b0);
    @(posedge clk);
    #1;
    check_output("rst_hold_req", req, 1'b0);
    check_output("rst_hold_count", fifo_count, 0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    grant    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    grant    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    apply_reset();

    $display("[TB] two words, grant tied to req");
    apply_stimulus(1, 8'hA1, 0, 1);
    apply_stimulus(1, 8'hA2, 0, 1);
    repeat (3) apply_stimulus(0, 8'h00, 0, 1);

    $display("[TB] six words, burst limit and yield");
    for (int i = 0; i < 6; i++) apply_stimulus(1, 8'hB0 + 8'(i), 0, 1);
    repeat (8) apply_stimulus(0, 8'h00, 0, 1);

    $display("[TB] starvation");
    for (int i = 0; i < 3; i++) apply_stimulus(1, 8'hC0 + 8'(i), 0, 0);
    repeat (17) apply_stimulus(0, 8'h00, 0, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    repeat (4) apply_stimulus(0, 8'h00, 0, 1);

    $display("[TB] full buffer and dropped word");
    for (int i = 0; i < 9; i++) apply_stimulus(1, 8'hD0 + 8'(i), 0, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    apply_stimulus(0, 8'h00, 0, 0);
    repeat (12) apply_stimulus(0, 8'h00, 0, 1);

    $display("[TB] spurious grant with empty buffer");
    apply_stimulus(0, 8'h00, 1, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    apply_stimulus(0, 8'h00, 0, 0);

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 4; i++) apply_stimulus(1, 8'hE0 + 8'(i), 0, 0);
    repeat (2) apply_stimulus(0, 8'h00, 1, 0);
    apply_reset();
    apply_stimulus(1, 8'h55, 0, 1);
    repeat (3) apply_stimulus(0, 8'h00, 0, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      apply_stimulus($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 3) != 0, 0);
    for (int i = 0; i < 200; i++)
      apply_stimulus($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 9) == 0, 0);
    for (int i = 0; i < 200; i++)
      apply_stimulus($urandom_range(0, 1), 8'($urandom), 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
